// File: rtl/rom_fetch_arbiter.sv
// Two-port arbiter/sequencer for a byte-wide ROM read port; assembles 1-4 bytes big-endian.
// Optional round-robin arbitration when ROM_ARB_ROUND_ROBIN_EN is defined (default: port 0 fixed priority).
module rom_fetch_arbiter #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [1:0]               len0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [1:0]               len1,
  output logic [1:0]               grant,
  output logic [1:0]               done,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic                     mem_start,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic                     mem_ready,
  input  logic [7:0]               mem_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] base;
    logic [1:0]               len;
  } txn_t;

  state_t                 state, state_n;
  txn_t                   txn, txn_n;
  logic [1:0]             count, count_n;
  logic [23:0]            acc, acc_n;      // bytes captured so far; the newest byte joins on the fly
  logic [31:0]            rdata_q, rdata_n;
  logic [1:0]             grant_q, grant_n;
  logic                   sel;             // 0 = port 0, 1 = port 1
  logic [ADDRESS_WIDTH-1:0] count_ext;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic last_grant, last_grant_n;

  always_comb begin
    if (req == 2'b11) sel = ~last_grant;
    else              sel = ~req[0];
  end
`else
  always_comb sel = ~req[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txn     <= '0;
      count   <= '0;
      acc     <= '0;
      rdata_q <= '0;
      grant_q <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state   <= state_n;
      txn     <= txn_n;
      count   <= count_n;
      acc     <= acc_n;
      rdata_q <= rdata_n;
      grant_q <= grant_n;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      last_grant <= last_grant_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    txn_n   = txn;
    count_n = count;
    acc_n   = acc;
    rdata_n = rdata_q;
    grant_n = grant_q;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    last_grant_n = last_grant;
`endif
    unique case (state)
      IDLE: begin
        if (|req) begin
          txn_n.base = sel ? addr1 : addr0;
          txn_n.len  = sel ? len1  : len0;
          count_n    = '0;
          acc_n      = '0;
          grant_n    = sel ? 2'b10 : 2'b01;
`ifdef ROM_ARB_ROUND_ROBIN_EN
          last_grant_n = sel;
`endif
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) state_n = WAIT;
      end
      WAIT: begin
        // mem_ready is low the cycle after the strobe, so the first high is fresh data
        if (mem_ready) begin
          acc_n   = {acc[15:0], mem_data};
          count_n = count + 2'd1;
          if (count == txn.len) begin
            rdata_n = {acc, mem_data};
            state_n = DONE;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      DONE: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    count_ext = '0;
    count_ext[1:0] = count;
  end

  assign mem_start   = (state == ISSUE) && mem_ready;
  assign mem_address = (state == ISSUE) ? txn.base + count_ext : '0;
  assign done        = (state == DONE) ? grant_q : 2'b00;
  assign busy        = (state != IDLE);
  assign grant       = grant_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a behavioural ROM that adds addr[1:0] wait cycles per read.
module tb_rom_fetch_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [7:0]  addr0, addr1;
  logic [1:0]  len0, len1;
  logic [1:0]  grant, done;
  logic [31:0] rdata;
  logic        busy, mem_start, mem_ready;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data = 8'h00;

  logic [7:0]  rom [256];
  int          rom_cnt = 0;
  logic        hold_low = 1'b0;
  logic [7:0]  starts [$];
  int          checks = 0;
  int          errors = 0;

  rom_fetch_arbiter #(.ADDRESS_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .addr0(addr0), .len0(len0), .addr1(addr1), .len1(len1),
    .grant(grant), .done(done), .rdata(rdata), .busy(busy),
    .mem_start(mem_start), .mem_address(mem_address),
    .mem_ready(mem_ready), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // ROM: ready drops after a strobe for 1 + addr[1:0] cycles, data held until the next strobe
  assign mem_ready = (rom_cnt == 0) && !hold_low;
  always @(posedge clk) begin
    if (mem_start) begin
      rom_cnt  <= 1 + int'(mem_address[1:0]);
      mem_data <= rom[mem_address];
    end else if (rom_cnt > 0) begin
      rom_cnt <= rom_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  // Runs from the current cycle until done pulses; returns at the negedge of the done cycle.
  task automatic run_txn(input logic [1:0] exp_g, output logic [1:0] dn, output logic [31:0] rd);
    bit seen = 0;
    dn = 2'b00;
    rd = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_start) starts.push_back(mem_address);
      if (busy && grant !== exp_g) check("grant_hold", {30'd0, grant}, {30'd0, exp_g});
      if (done != 2'b00) begin
        dn = done;
        rd = rdata;
        seen = 1;
        break;
      end
      next_cyc;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: no done within 200 cycles, required done=%b", exp_g);
    end
  endtask

  logic [1:0]  dn;
  logic [31:0] rd;
  logic [1:0]  exp_order [4];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i ^ 8'h5C);
    rom[8'h10] = 8'hB2;
    rom[8'h20] = 8'h11; rom[8'h21] = 8'h22; rom[8'h22] = 8'h33; rom[8'h23] = 8'h44;
    rom[8'h24] = 8'h5A;
    rom[8'hFE] = 8'hDE; rom[8'hFF] = 8'hAD; rom[8'h00] = 8'hBE; rom[8'h01] = 8'hEF;
    rom[8'h30] = 8'hC0; rom[8'h40] = 8'h41;
    reset = 1'b1; req = 2'b00; addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;

    // reset state
    next_cyc; next_cyc;
    @(negedge clk);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_start", {31'd0, mem_start}, 32'd0);
    check("rst_mem_address", {24'd0, mem_address}, 32'd0);
    next_cyc;
    reset = 1'b0;
    next_cyc;

    // single byte, port 0: cycle-exact latency
    req = 2'b01; addr0 = 8'h10; len0 = 2'd0;
    @(negedge clk);
    check("t1_c0_busy", {31'd0, busy}, 32'd0);
    next_cyc; @(negedge clk);
    check("t1_c1_grant", {30'd0, grant}, 32'd1);
    check("t1_c1_start", {31'd0, mem_start}, 32'd1);
    check("t1_c1_addr", {24'd0, mem_address}, 32'h10);
    next_cyc; @(negedge clk);
    check("t1_c2_start", {31'd0, mem_start}, 32'd0);
    next_cyc; @(negedge clk);
    check("t1_c3_done", {30'd0, done}, 32'd0);
    next_cyc; @(negedge clk);
    check("t1_c4_done", {30'd0, done}, 32'd1);
    check("t1_c4_rdata", rdata, 32'h0000_00B2);
    req = 2'b00;
    next_cyc; @(negedge clk);
    check("t1_c5_done", {30'd0, done}, 32'd0);
    check("t1_c5_grant", {30'd0, grant}, 32'd0);
    check("t1_c5_rdata_hold", rdata, 32'h0000_00B2);
    next_cyc;

    // four bytes, port 1
    starts.delete();
    req = 2'b10; addr1 = 8'h20; len1 = 2'd3;
    run_txn(2'b10, dn, rd);
    req = 2'b00;
    check("t2_done", {30'd0, dn}, 32'd2);
    check("t2_rdata", rd, 32'h1122_3344);
    check("t2_nstarts", starts.size(), 32'd4);
    for (int i = 0; i < 4 && i < starts.size(); i++)
      check("t2_addr", {24'd0, starts[i]}, 32'h20 + i);
    next_cyc; @(negedge clk);
    check("t2_single_pulse", {30'd0, done}, 32'd0);
    next_cyc;

    // address wrap
    starts.delete();
    req = 2'b01; addr0 = 8'hFE; len0 = 2'd3;
    run_txn(2'b01, dn, rd);
    req = 2'b00;
    check("wrap_rdata", rd, 32'hDEAD_BEEF);
    check("wrap_nstarts", starts.size(), 32'd4);
    if (starts.size() == 4) begin
      check("wrap_a0", {24'd0, starts[0]}, 32'hFE);
      check("wrap_a1", {24'd0, starts[1]}, 32'hFF);
      check("wrap_a2", {24'd0, starts[2]}, 32'h00);
      check("wrap_a3", {24'd0, starts[3]}, 32'h01);
    end
    next_cyc;

    // mem_ready held low five cycles in ISSUE
    hold_low = 1'b1;
    req = 2'b10; addr1 = 8'h24; len1 = 2'd0;
    for (int i = 0; i < 5; i++) begin
      next_cyc; @(negedge clk);
      check("hold_start_low", {31'd0, mem_start}, 32'd0);
      check("hold_busy", {31'd0, busy}, 32'd1);
    end
    next_cyc;
    hold_low = 1'b0;
    @(negedge clk);
    check("hold_start_pulse", {31'd0, mem_start}, 32'd1);
    check("hold_addr", {24'd0, mem_address}, 32'h24);
    next_cyc;
    run_txn(2'b10, dn, rd);
    req = 2'b00;
    check("hold_done", {30'd0, dn}, 32'd2);
    check("hold_rdata", rd, 32'h0000_005A);
    next_cyc;

    // both requesters held high for four transactions, from a fresh reset
    reset = 1'b1; next_cyc; reset = 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    req = 2'b11; addr0 = 8'h30; len0 = 2'd0; addr1 = 8'h40; len1 = 2'd0;
    for (int k = 0; k < 4; k++) begin
      run_txn(exp_order[k], dn, rd);
      check("arb_done", {30'd0, dn}, {30'd0, exp_order[k]});
      check("arb_rdata", rd, (exp_order[k] == 2'b01) ? 32'hC0 : 32'h41);
      if (k == 3) req = 2'b00;
      next_cyc;
    end

    // reset while in WAIT, with the ROM still mid-read afterwards
    req = 2'b01; addr0 = 8'h13; len0 = 2'd0;
    next_cyc; @(negedge clk);
    check("rstw_strobe", {31'd0, mem_start}, 32'd1);
    next_cyc;
    reset = 1'b1; req = 2'b00;
    next_cyc; @(negedge clk);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_grant", {30'd0, grant}, 32'd0);
    check("rstw_done", {30'd0, done}, 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    check("rstw_start", {31'd0, mem_start}, 32'd0);
    reset = 1'b0; req = 2'b01; addr0 = 8'h10; len0 = 2'd0;
    for (int i = 0; i < 2; i++) begin
      next_cyc; @(negedge clk);
      check("rstw_wait_issue", {31'd0, mem_start}, 32'd0);
    end
    next_cyc; @(negedge clk);
    check("rstw_late_strobe", {31'd0, mem_start}, 32'd1);
    next_cyc;
    run_txn(2'b01, dn, rd);
    req = 2'b00;
    check("rstw_done_after", {30'd0, dn}, 32'd1);
    check("rstw_rdata_after", rd, 32'h0000_00B2);
    next_cyc; next_cyc;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
